timer555_oneshot_sched: RTL and testbench

- Digital scheduler that shares one timer555 instance, wired as a monostable, among N_REQ requesters.
- Arbitrates round-robin, fires the trigger pin, and resets the timer on faults.
- Measures the resulting output pulse width in clk cycles and returns it to the granted requester.
- Sits between the digital control fabric and the mixed-signal 555 pins (trig, reset, out).

---
 rtl/timer555_sched_pkg.sv | 33 +++
 rtl/timer555_rr_arb.sv | 39 +++
 rtl/timer555_oneshot_sched.sv | 198 +++++++++++++++++++
 tb/tb_timer555_oneshot_sched.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer555_sched_pkg.sv
// Shared types and defaults for the 555 one-shot scheduler.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package timer555_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_HI,
    MEASURE,
    DONE,
    RECOVER
  } state_t;

  localparam int DEF_N_REQ          = 4;
  localparam int DEF_CNT_W          = 16;
  localparam int DEF_TRIG_CYCLES    = 4;
  localparam int DEF_RST_CYCLES     = 8;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_SYNC_STAGES    = 2;

  // Index of the set bit in a one-hot vector of up to 16 requesters.
  // A zero vector returns 0.
  function automatic int unsigned onehot_to_idx(input logic [15:0] i_oh);
    int unsigned r_idx;
    r_idx = 0;
    for (int k = 0; k < 16; k++) begin
      if (i_oh[k]) r_idx = unsigned'(k);
    end
    return r_idx;
  endfunction

endpackage

// File: rtl/timer555_rr_arb.sv
// Combinational round-robin pick: first set request at or after the pointer, with wrap.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when to sample o_grant.
//   i_req   : request vector
//   i_ptr   : index with highest priority this round
//   o_grant : one-hot pick (zero when no request)
//   o_valid : at least one request is set
module timer555_rr_arb
  import timer555_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic             o_valid
);

  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  logic [N_REQ-1:0] w_mask;
  logic [N_REQ-1:0] w_masked;
  logic [N_REQ-1:0] w_sel;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_mask[i] = (i >= int'(i_ptr));
    end
    // Requests at/after the pointer win; if none, wrap to the full vector.
    w_masked = i_req & w_mask;
    w_sel    = (w_masked != '0) ? w_masked : i_req;
    // Isolate the lowest set bit.
    o_grant  = w_sel & (~w_sel + ONE);
    o_valid  = |i_req;
  end

endmodule

// File: rtl/timer555_oneshot_sched.sv
// Shares one monostable 555 among N_REQ requesters: round-robin grant, trigger, measure out high-time.
// Latency: TRIG_CYCLES + time to out rise + pulse width + SYNC_STAGES, plus one DONE cycle per job.
// Backpressure: req is a level; sampled only in IDLE, grant held until the job ends (done or err).
//   clk/rst          : clock, synchronous active-high reset
//   req/grant/done   : level requests, one-hot job grant, one-cycle completion pulse
//   err              : one-cycle pulse on rise timeout or width counter saturation
//   width_q          : last measured out high-time in clk cycles
//   trig_n/reset_n   : 555 trigger and reset pins (active low)
//   out_in           : 555 output pin, asynchronous
//   busy             : state is not IDLE
module timer555_oneshot_sched
  import timer555_sched_pkg::*;
#(
  parameter int N_REQ          = DEF_N_REQ,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int RST_CYCLES     = DEF_RST_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] done,
  output logic             err,
  output logic [CNT_W-1:0] width_q,
  output logic             trig_n,
  output logic             reset_n,
  input  logic             out_in,
  output logic             busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(N_REQ - 1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [N_REQ-1:0]       r_grant;
  logic [PTR_W-1:0]       r_ptr;
  logic [N_REQ-1:0]       r_done;
  logic                   r_err;
  logic [CNT_W-1:0]       r_width;
  logic                   r_trig_n;
  logic                   r_reset_n;
  logic                   r_busy;
  logic [SYNC_STAGES-1:0] r_sync;

  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [N_REQ-1:0]       w_grant_nxt;
  logic [PTR_W-1:0]       w_ptr_nxt;
  logic [N_REQ-1:0]       w_done_nxt;
  logic                   w_err_nxt;
  logic [CNT_W-1:0]       w_width_nxt;

  logic                   w_out_s;
  logic [N_REQ-1:0]       w_arb_grant;
  logic                   w_arb_vld;
  logic [PTR_W-1:0]       w_gidx;
  logic [PTR_W-1:0]       w_ptr_adv;

  assign w_out_s   = r_sync[SYNC_STAGES-1];
  assign w_gidx    = PTR_W'(onehot_to_idx(16'(r_grant)));
  assign w_ptr_adv = (w_gidx == LAST_IDX) ? '0 : (w_gidx + PTR_ONE);

  timer555_rr_arb #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_valid (w_arb_vld)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_done_nxt  = '0;
    w_err_nxt   = 1'b0;
    w_width_nxt = r_width;
    case (r_state)
      IDLE: begin
        // A high output before any trigger is a stuck latch: clear it first.
        if (w_out_s) begin
          w_state_nxt = RECOVER;
          w_cnt_nxt   = '0;
        end else if (w_arb_vld) begin
          w_grant_nxt = w_arb_grant;
          w_state_nxt = TRIG;
          w_cnt_nxt   = '0;
        end
      end
      TRIG: begin
        if (r_cnt == TRIG_LAST) begin
          w_state_nxt = WAIT_HI;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      WAIT_HI: begin
        // The cycle out_s is first seen high counts as the first high cycle.
        if (w_out_s) begin
          w_state_nxt = MEASURE;
          w_cnt_nxt   = CNT_ONE;
        end else if (r_cnt == TMO_LAST) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = RECOVER;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      MEASURE: begin
        if (!w_out_s) begin
          w_width_nxt = r_cnt;
          w_done_nxt  = r_grant;
          w_state_nxt = DONE;
        end else if (r_cnt == '1) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = RECOVER;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      DONE: begin
        w_grant_nxt = '0;
        w_ptr_nxt   = w_ptr_adv;
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
      RECOVER: begin
        if (r_cnt == RST_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_grant_nxt = '0;
          // Only a failed job moves the pointer; a stale-output pass does not.
          if (|r_grant) w_ptr_nxt = w_ptr_adv;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = RECOVER;
        w_cnt_nxt   = '0;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RECOVER;
      r_cnt     <= '0;
      r_grant   <= '0;
      r_ptr     <= '0;
      r_done    <= '0;
      r_err     <= 1'b0;
      r_width   <= '0;
      r_trig_n  <= 1'b1;
      r_reset_n <= 1'b0;
      r_busy    <= 1'b1;
      r_sync    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_grant   <= w_grant_nxt;
      r_ptr     <= w_ptr_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_width   <= w_width_nxt;
      // Pin drives are registered from the next state so they never glitch.
      r_trig_n  <= (w_state_nxt != TRIG);
      r_reset_n <= (w_state_nxt != RECOVER);
      r_busy    <= (w_state_nxt != IDLE);
      r_sync    <= {r_sync[SYNC_STAGES-2:0], out_in};
    end
  end

  assign grant   = r_grant;
  assign done    = r_done;
  assign err     = r_err;
  assign width_q = r_width;
  assign trig_n  = r_trig_n;
  assign reset_n = r_reset_n;
  assign busy    = r_busy;

endmodule

// File: tb/tb_timer555_oneshot_sched.sv
module tb_timer555_oneshot_sched;

  localparam int N_REQ          = 4;
  localparam int CNT_W          = 11;
  localparam int TRIG_CYCLES    = 4;
  localparam int RST_CYCLES     = 8;
  localparam int TIMEOUT_CYCLES = 1024;
  localparam int SYNC_STAGES    = 2;
  localparam int MAX_W          = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] done;
  logic             err;
  logic [CNT_W-1:0] width_q;
  logic             trig_n;
  logic             reset_n;
  logic             out_in;
  logic             busy;

  timer555_oneshot_sched #(
    .N_REQ          (N_REQ),
    .CNT_W          (CNT_W),
    .TRIG_CYCLES    (TRIG_CYCLES),
    .RST_CYCLES     (RST_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .grant   (grant),
    .done    (done),
    .err     (err),
    .width_q (width_q),
    .trig_n  (trig_n),
    .reset_n (reset_n),
    .out_in  (out_in),
    .busy    (busy)
  );

  typedef struct {
    bit is_err;
    int idx;
    int width;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  int   pulse_q[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   cyc    = 0;
  int   t_rise = 0;
  bit   stale  = 0;
  int   m_ptr  = 0;
  int   m_width = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  // Reference: the served requester is the set bit at the smallest
  // circular distance from the pointer.
  function automatic int pick(input logic [N_REQ-1:0] r, input int ptr);
    for (int k = 0; k < N_REQ; k++) begin
      if (r[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
    end
    return -1;
  endfunction

  // 555 monostable model: out goes high for pulse_q.front() cycles after the
  // trigger is released (0 = never rises); reset_n low clears it; stale forces high.
  initial begin
    int   hi_left;
    int   p;
    logic trig_prev;
    hi_left   = 0;
    trig_prev = 1'bx;
    out_in    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stale) begin
        out_in = 1'b1;
      end else if (reset_n === 1'b0) begin
        out_in  = 1'b0;
        hi_left = 0;
      end else if (hi_left > 0) begin
        hi_left--;
        if (hi_left == 0) out_in = 1'b0;
      end else begin
        out_in = 1'b0;
        if (trig_prev === 1'b0 && trig_n === 1'b1) begin
          p = (pulse_q.size() > 0) ? pulse_q.pop_front() : 0;
          if (p > 0) begin
            out_in  = 1'b1;
            hi_left = p;
          end
        end
      end
      trig_prev = trig_n;
    end
  end

  // Trigger-width monitor.
  initial begin
    int lo;
    lo = 0;
    forever begin
      @(negedge clk);
      if (rst) lo = 0;
      else if (trig_n == 1'b0) lo++;
      else if (lo > 0) begin
        check("trig_low_cycles", lo, TRIG_CYCLES);
        t_rise = cyc;
        lo = 0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (done != '0 || err)) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: done=%b err=%b, required no output", done, err);
        end else begin
          e = exp_q.pop_front();
          check("kind_err", int'(err), int'(e.is_err));
          check("grant_at_end", int'(grant), 1 << e.idx);
          if (e.is_err) check("done_on_err", int'(done), 0);
          else check("done_bit", int'(done), 1 << e.idx);
          check("width_q", int'(width_q), e.width);
          if (e.lat > 0) check("timeout_latency", cyc - t_rise, e.lat);
        end
      end
    end
  end

  task automatic start_job(input logic [N_REQ-1:0] r, input int pulse);
    exp_t e;
    e.idx = pick(r, m_ptr);
    e.lat = 0;
    if (pulse == 0) begin
      e.is_err = 1'b1;
      e.width  = m_width;
      e.lat    = TIMEOUT_CYCLES;
    end else if (pulse > MAX_W) begin
      e.is_err = 1'b1;
      e.width  = m_width;
    end else begin
      e.is_err = 1'b0;
      e.width  = pulse;
      m_width  = pulse;
    end
    m_ptr = (e.idx + 1) % N_REQ;
    exp_q.push_back(e);
    pulse_q.push_back(pulse);
    req = r;
  endtask

  task automatic finish_job(input bit drop, input bit chk_gap);
    int n;
    n = 0;
    while (grant == '0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (grant == '0) bound_fail("grant_wait");
    else if (chk_gap) check("idle_gap_cycles", n, 1);
    if (drop) req = '0;
    n = 0;
    while (done == '0 && !err && n < TIMEOUT_CYCLES + MAX_W + 200) begin
      n++;
      @(negedge clk);
    end
    if (done == '0 && !err) bound_fail("job_end_wait");
    n = 0;
    while (grant != '0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (grant != '0) bound_fail("grant_release");
  endtask

  task automatic check_reset_outputs();
    check("rst_grant", int'(grant), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_width_q", int'(width_q), 0);
    check("rst_trig_n", int'(trig_n), 1);
    check("rst_reset_n", int'(reset_n), 0);
    check("rst_busy", int'(busy), 1);
  endtask

  task automatic count_reset_low(input string name);
    int n;
    n = 0;
    while (reset_n == 1'b0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check(name, n, RST_CYCLES);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    int g;
    int rf;
    logic prev;
    req = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    count_reset_low("recover_after_reset");

    // Single shot, 100-cycle pulse.
    start_job(4'b0001, 100);
    finish_job(1'b1, 1'b0);

    // Held requests: round-robin, one IDLE cycle between jobs.
    for (int j = 0; j < 4; j++) begin
      start_job(4'b1011, 10);
      finish_job(j == 3, j > 0);
    end

    // Rise timeout, then next requester served.
    start_job(4'b0100, 0);
    finish_job(1'b1, 1'b0);
    start_job(4'b0101, 20);
    finish_job(1'b1, 1'b0);

    // Width boundaries: minimum, largest measurable, saturation.
    start_job(4'b1000, 1);
    finish_job(1'b1, 1'b0);
    start_job(4'b0010, MAX_W);
    finish_job(1'b1, 1'b0);
    start_job(4'b0100, MAX_W + 1);
    finish_job(1'b1, 1'b0);

    // Stale output while requests wait.
    stale = 1'b1;
    repeat (6) @(negedge clk);
    start_job(4'b0010, 40);
    g = 0;
    rf = 0;
    prev = reset_n;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (grant != '0) g++;
      if (prev && !reset_n) rf++;
      prev = reset_n;
    end
    check("stale_grant_cycles", g, 0);
    check("stale_recover_repeats", int'(rf >= 2), 1);
    stale = 1'b0;
    finish_job(1'b1, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 12; j++) begin
      logic [N_REQ-1:0] r;
      r = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      start_job(r, int'($urandom_range(1, 300)));
      finish_job(1'b1, 1'b0);
    end

    // Reset in the middle of a measurement: no done, fresh recover.
    pulse_q.push_back(500);
    req = 4'b0001;
    n = 0;
    while (grant == '0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (grant == '0) bound_fail("mid_grant_wait");
    req = '0;
    n = 0;
    while (out_in == 1'b0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (out_in == 1'b0) bound_fail("mid_out_wait");
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    m_ptr = 0;
    m_width = 0;
    @(negedge clk);
    count_reset_low("recover_after_mid_reset");
    start_job(4'b1111, 50);
    finish_job(1'b1, 1'b0);

    repeat (20) @(negedge clk);
    check("expected_left", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
